cpu6_trap_ctrl: RTL and testbench

CPU6_TRAP_CTRL -- requirements
Module: cpu6_trap_ctrl

---
 rtl/cpu6_trap_pkg.sv | 6 +
 rtl/cpu6_irq_arb.sv | 22 ++
 rtl/cpu6_trap_ctrl.sv | 86 ++++++++
 tb/tb_cpu6_trap_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu6_trap_pkg.sv
// cpu6_trap_pkg: trap controller state type and interrupt cause codes
package cpu6_trap_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN_IRQ, DRAIN_MRET, REDIRECT} cpu6_trap_state_t;
  localparam logic [4:0] CPU6_MCAUSE_MEI = 5'd11;
  localparam logic [4:0] CPU6_MCAUSE_MTI = 5'd7;
endpackage

// File: rtl/cpu6_irq_arb.sv
// cpu6_irq_arb: interrupt pending/priority/cause encoder; ext irq only counts with CPU6_EXT_IRQ_EN
module cpu6_irq_arb import cpu6_trap_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            tmr_irq_r,
  input  logic            ext_irq_r,
  input  logic            csr_mtie_r,
  input  logic            csr_mstatus_mie_r,
  output logic            pending,
  output logic [XLEN-1:0] cause
);
`ifdef CPU6_EXT_IRQ_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif
  logic ext, tmr;
  assign ext = ext_irq_r & EXT_EN;
  assign tmr = tmr_irq_r & csr_mtie_r;
  assign pending = csr_mstatus_mie_r & (ext | tmr);
  assign cause = {1'b1, {(XLEN-6){1'b0}}, ext ? CPU6_MCAUSE_MEI : CPU6_MCAUSE_MTI};
endmodule

// File: rtl/cpu6_trap_ctrl.sv
// cpu6_trap_ctrl: interrupt/MRET trap sequencer (drain, CSR update, fetch redirect)
// CPU6_EXT_IRQ_EN: when defined, ext_irq_r raises traps and outranks the timer
module cpu6_trap_ctrl import cpu6_trap_pkg::*; #(
  parameter int CPU6_XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tmr_irq_r,
  input  logic                 ext_irq_r,
  input  logic                 csr_mtie_r,
  input  logic                 csr_mstatus_mie_r,
  input  logic                 instr_validE,
  input  logic                 mret_instrE,
  input  logic [CPU6_XLEN-1:0] pcE,
  input  logic [CPU6_XLEN-1:0] pcnextE,
  input  logic                 pcsrcE,
  input  logic [CPU6_XLEN-1:0] csr_mtvec,
  input  logic [CPU6_XLEN-1:0] csr_mepc,
  output logic                 empty_pipeline_reqE,
  input  logic                 empty_pipeline_ackW,
  output logic [CPU6_XLEN-1:0] excp_mepc,
  output logic                 excp_mepc_ena,
  output logic [CPU6_XLEN-1:0] excp_mcause,
  output logic                 mret_ena,
  output logic                 stallF,
  output logic                 redirect_ena,
  output logic [CPU6_XLEN-1:0] redirect_pc
);
  cpu6_trap_state_t state;
  logic pending, accept, unused;
  logic [CPU6_XLEN-1:0] cause;
  cpu6_irq_arb #(.XLEN(CPU6_XLEN)) u_arb (
    .tmr_irq_r(tmr_irq_r),
    .ext_irq_r(ext_irq_r),
    .csr_mtie_r(csr_mtie_r),
    .csr_mstatus_mie_r(csr_mstatus_mie_r),
    .pending(pending),
    .cause(cause)
  );
  assign unused = ^{pcE, pcsrcE};
  assign accept = instr_validE & (mret_instrE | pending);
  // the drain tag must ride on the instruction currently in E, so it is not registered
  assign empty_pipeline_reqE = reset & (state == IDLE) & accept;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      stallF        <= 1'b0;
      excp_mepc_ena <= 1'b0;
      mret_ena      <= 1'b0;
      redirect_ena  <= 1'b0;
      redirect_pc   <= '0;
      excp_mepc     <= '0;
      excp_mcause   <= '0;
    end else begin
      excp_mepc_ena <= 1'b0;
      mret_ena      <= 1'b0;
      redirect_ena  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state  <= mret_instrE ? DRAIN_MRET : DRAIN_IRQ;
          stallF <= 1'b1;
          if (!mret_instrE) begin
            excp_mepc   <= pcnextE;
            excp_mcause <= cause;
          end
        end
        DRAIN_IRQ: if (empty_pipeline_ackW) begin
          state         <= REDIRECT;
          excp_mepc_ena <= 1'b1;
          redirect_ena  <= 1'b1;
          redirect_pc   <= csr_mtvec;
        end
        DRAIN_MRET: if (empty_pipeline_ackW) begin
          state        <= REDIRECT;
          mret_ena     <= 1'b1;
          redirect_ena <= 1'b1;
          redirect_pc  <= csr_mepc;
        end
        default: begin
          state  <= IDLE;
          stallF <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// tb_cpu6_trap_ctrl: directed self-checking bench for cpu6_trap_ctrl
module tb_cpu6_trap_ctrl;
  logic clk = 1'b0;
  logic reset, tmr_irq_r, ext_irq_r, csr_mtie_r, csr_mstatus_mie_r;
  logic instr_validE, mret_instrE, pcsrcE, empty_pipeline_ackW;
  logic [31:0] pcE, pcnextE, csr_mtvec, csr_mepc;
  logic empty_pipeline_reqE, excp_mepc_ena, mret_ena, stallF, redirect_ena;
  logic [31:0] excp_mepc, excp_mcause, redirect_pc;
  int checks = 0;
  int errors = 0;
`ifdef CPU6_EXT_IRQ_EN
  localparam logic EXT = 1'b1;
  localparam logic [31:0] PRIO_CAUSE = 32'h8000000B;
`else
  localparam logic EXT = 1'b0;
  localparam logic [31:0] PRIO_CAUSE = 32'h80000007;
`endif

  always #5 clk = ~clk;

  cpu6_trap_ctrl dut (
    .clk(clk), .reset(reset), .tmr_irq_r(tmr_irq_r), .ext_irq_r(ext_irq_r),
    .csr_mtie_r(csr_mtie_r), .csr_mstatus_mie_r(csr_mstatus_mie_r),
    .instr_validE(instr_validE), .mret_instrE(mret_instrE), .pcE(pcE),
    .pcnextE(pcnextE), .pcsrcE(pcsrcE), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .empty_pipeline_reqE(empty_pipeline_reqE), .empty_pipeline_ackW(empty_pipeline_ackW),
    .excp_mepc(excp_mepc), .excp_mepc_ena(excp_mepc_ena), .excp_mcause(excp_mcause),
    .mret_ena(mret_ena), .stallF(stallF), .redirect_ena(redirect_ena), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_validE = 1'b1; tmr_irq_r = 1'b1; csr_mtie_r = 1'b1; csr_mstatus_mie_r = 1'b1;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", empty_pipeline_reqE); end
    tick();
    checks++; if ({stallF, excp_mepc_ena, mret_ena, redirect_ena} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {stallF, excp_mepc_ena, mret_ena, redirect_ena}); end
    checks++; if ({excp_mepc, excp_mcause, redirect_pc} !== 96'h0) begin errors++; $display("FAIL rst_regs got %h %h %h exp 0", excp_mepc, excp_mcause, redirect_pc); end
    instr_validE = 1'b0; tmr_irq_r = 1'b0; reset = 1'b1;
    tick();
  endtask

  task automatic test_timer();
    tmr_irq_r = 1'b1; instr_validE = 1'b1; pcE = 32'hFC; pcnextE = 32'h100;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b1) begin errors++; $display("FAIL tmr_req got %0b exp 1", empty_pipeline_reqE); end
    tick();
    instr_validE = 1'b0;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b0) begin errors++; $display("FAIL tmr_req_pulse got %0b exp 0", empty_pipeline_reqE); end
    checks++; if (stallF !== 1'b1) begin errors++; $display("FAIL tmr_stall got %0b exp 1", stallF); end
    checks++; if (excp_mepc !== 32'h100 || excp_mcause !== 32'h80000007) begin errors++; $display("FAIL tmr_latch got %h %h exp 00000100 80000007", excp_mepc, excp_mcause); end
    tick();
    empty_pipeline_ackW = 1'b1;
    tick();
    empty_pipeline_ackW = 1'b0;
    checks++; if ({excp_mepc_ena, redirect_ena, stallF, mret_ena} !== 4'b1110) begin errors++; $display("FAIL tmr_commit got %b exp 1110", {excp_mepc_ena, redirect_ena, stallF, mret_ena}); end
    checks++; if (redirect_pc !== 32'h40) begin errors++; $display("FAIL tmr_rpc got %h exp 00000040", redirect_pc); end
    tick();
    checks++; if ({excp_mepc_ena, redirect_ena, stallF} !== 3'b000) begin errors++; $display("FAIL tmr_idle got %b exp 000", {excp_mepc_ena, redirect_ena, stallF}); end
    checks++; if (excp_mepc !== 32'h100) begin errors++; $display("FAIL tmr_hold got %h exp 00000100", excp_mepc); end
    tmr_irq_r = 1'b0;
  endtask

  task automatic test_priority();
    ext_irq_r = 1'b1; tmr_irq_r = 1'b1; instr_validE = 1'b1; pcnextE = 32'h200;
    tick();
    instr_validE = 1'b0; ext_irq_r = 1'b0; tmr_irq_r = 1'b0;
    checks++; if (excp_mcause !== PRIO_CAUSE) begin errors++; $display("FAIL prio_cause got %h exp %h", excp_mcause, PRIO_CAUSE); end
    empty_pipeline_ackW = 1'b1;
    tick();
    empty_pipeline_ackW = 1'b0;
    tick();
    ext_irq_r = 1'b1; instr_validE = 1'b1;
    #1;
    checks++; if (empty_pipeline_reqE !== EXT) begin errors++; $display("FAIL ext_only_req got %0b exp %0b", empty_pipeline_reqE, EXT); end
    tick();
    instr_validE = 1'b0; ext_irq_r = 1'b0; empty_pipeline_ackW = 1'b1;
    tick();
    empty_pipeline_ackW = 1'b0;
    tick();
    checks++; if (stallF !== 1'b0 || excp_mcause !== PRIO_CAUSE) begin errors++; $display("FAIL ext_only_end got %0b %h exp 0 %h", stallF, excp_mcause, PRIO_CAUSE); end
  endtask

  task automatic test_mret();
    tmr_irq_r = 1'b1; instr_validE = 1'b1; mret_instrE = 1'b1; pcnextE = 32'h300;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b1) begin errors++; $display("FAIL mret_req got %0b exp 1", empty_pipeline_reqE); end
    tick();
    instr_validE = 1'b0; mret_instrE = 1'b0;
    checks++; if (stallF !== 1'b1 || excp_mepc !== 32'h200) begin errors++; $display("FAIL mret_drain got %0b %h exp 1 00000200", stallF, excp_mepc); end
    empty_pipeline_ackW = 1'b1;
    tick();
    empty_pipeline_ackW = 1'b0;
    checks++; if ({mret_ena, redirect_ena, excp_mepc_ena} !== 3'b110) begin errors++; $display("FAIL mret_commit got %b exp 110", {mret_ena, redirect_ena, excp_mepc_ena}); end
    checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL mret_rpc got %h exp 00000204", redirect_pc); end
    tick();
    checks++; if (mret_ena !== 1'b0 || stallF !== 1'b0) begin errors++; $display("FAIL mret_idle got %0b %0b exp 0 0", mret_ena, stallF); end
    instr_validE = 1'b1; pcnextE = 32'h400;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b1) begin errors++; $display("FAIL mret_irq_req got %0b exp 1", empty_pipeline_reqE); end
    tick();
    instr_validE = 1'b0; tmr_irq_r = 1'b0;
    checks++; if (excp_mepc !== 32'h400 || excp_mcause !== 32'h80000007) begin errors++; $display("FAIL mret_irq_latch got %h %h exp 00000400 80000007", excp_mepc, excp_mcause); end
    empty_pipeline_ackW = 1'b1;
    tick();
    empty_pipeline_ackW = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    tmr_irq_r = 1'b1; instr_validE = 1'b1; pcnextE = 32'h500;
    tick();
    instr_validE = 1'b0; tmr_irq_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (stallF !== 1'b1 || excp_mepc_ena !== 1'b0) begin errors++; $display("FAIL drop_wait%0d got %0b %0b exp 1 0", i, stallF, excp_mepc_ena); end
      tick();
    end
    empty_pipeline_ackW = 1'b1;
    tick();
    empty_pipeline_ackW = 1'b0;
    checks++; if ({excp_mepc_ena, redirect_ena, stallF} !== 3'b111 || excp_mepc !== 32'h500) begin errors++; $display("FAIL drop_commit got %b %h exp 111 00000500", {excp_mepc_ena, redirect_ena, stallF}, excp_mepc); end
    tick();
    checks++; if (stallF !== 1'b0) begin errors++; $display("FAIL drop_idle got %0b exp 0", stallF); end
  endtask

  task automatic test_reset_mid();
    tmr_irq_r = 1'b1; instr_validE = 1'b1; pcnextE = 32'h600;
    tick();
    instr_validE = 1'b0; tmr_irq_r = 1'b0;
    checks++; if (stallF !== 1'b1) begin errors++; $display("FAIL rmid_stall got %0b exp 1", stallF); end
    reset = 1'b0; empty_pipeline_ackW = 1'b1;
    tick();
    reset = 1'b1;
    checks++; if ({stallF, excp_mepc_ena, redirect_ena} !== 3'b000 || excp_mepc !== 32'h0 || excp_mcause !== 32'h0) begin errors++; $display("FAIL rmid_clear got %b %h %h exp 000 0 0", {stallF, excp_mepc_ena, redirect_ena}, excp_mepc, excp_mcause); end
    tick();
    empty_pipeline_ackW = 1'b0;
    checks++; if ({excp_mepc_ena, redirect_ena, stallF} !== 3'b000) begin errors++; $display("FAIL rmid_ack_ignored got %b exp 000", {excp_mepc_ena, redirect_ena, stallF}); end
    tick();
  endtask

  task automatic test_no_trap();
    csr_mstatus_mie_r = 1'b0; tmr_irq_r = 1'b1; instr_validE = 1'b1;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b0) begin errors++; $display("FAIL nomie_req got %0b exp 0", empty_pipeline_reqE); end
    tick();
    checks++; if (stallF !== 1'b0) begin errors++; $display("FAIL nomie_stall got %0b exp 0", stallF); end
    csr_mstatus_mie_r = 1'b1; instr_validE = 1'b0;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b0) begin errors++; $display("FAIL noval_req got %0b exp 0", empty_pipeline_reqE); end
    tick();
    checks++; if (stallF !== 1'b0) begin errors++; $display("FAIL noval_stall got %0b exp 0", stallF); end
    csr_mtie_r = 1'b0; instr_validE = 1'b1;
    #1;
    checks++; if (empty_pipeline_reqE !== 1'b0) begin errors++; $display("FAIL nomtie_req got %0b exp 0", empty_pipeline_reqE); end
    tick();
    instr_validE = 1'b0; tmr_irq_r = 1'b0; csr_mtie_r = 1'b1;
  endtask

  initial begin
    reset = 1'b0; tmr_irq_r = 1'b0; ext_irq_r = 1'b0; csr_mtie_r = 1'b0; csr_mstatus_mie_r = 1'b0;
    instr_validE = 1'b0; mret_instrE = 1'b0; pcsrcE = 1'b0; empty_pipeline_ackW = 1'b0;
    pcE = 32'h0; pcnextE = 32'h0; csr_mtvec = 32'h40; csr_mepc = 32'h204;
    tick();
    test_reset();
    test_timer();
    test_priority();
    test_mret();
    test_drop();
    test_reset_mid();
    test_no_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
